bram_fifo_ctrl: RTL and testbench

- Stream-in/stream-out FIFO controller that owns both ports of the external dual-port RAM instance.
- Write side: accepts a valid/ready stream and drives RAM port A (ena/wea/addra/dina).
- Read side: drives RAM port B (enb/addrb/regceb/rstnb) and treats the RAM's two read registers as a fully stallable 2-stage pipeline presenting a valid/ready output stream.
- Sits between producer datapath and consumer; the RAM itself stays a separate instance.

---
 rtl/bram_fifo_pkg.sv | 25 ++
 rtl/bram_rd_pipe.sv | 50 +++++
 rtl/bram_fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bram_fifo_pkg
// Shared helpers for the BRAM-backed FIFO controller:
//   depth_of()   - FIFO depth derived from the number of RAM address lines
//   ptr_bits()   - width of the read/write pointers
//   level_bits() - width of the fill-level counter (must be able to hold DEPTH)
//   RD_LAT       - number of RAM read registers treated as pipeline stages
// -----------------------------------------------------------------------------
package bram_fifo_pkg;

    localparam int RD_LAT = 2;

    function automatic int depth_of(input int addr_lines);
        return 1 << addr_lines;
    endfunction

    function automatic int ptr_bits(input int addr_lines);
        return addr_lines;
    endfunction

    function automatic int level_bits(input int addr_lines);
        return addr_lines + 1;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// -----------------------------------------------------------------------------
// bram_rd_pipe
// Tracks the valid bits of the RAM's two read registers (ram_data_b = stage 1,
// doutb = stage 2) and decides when each register may load, so that the pair
// behaves as a fully stallable two-stage pipeline.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - synchronous discard of everything in flight
//   have_data   - at least one written word is waiting to be issued
//   out_ready   - consumer accepts the stage-2 word
//   issue       - load stage 1 (RAM port B enable), advances the read pointer
//   adv2        - load stage 2 (RAM output-register clock enable)
//   out_valid   - stage 2 holds a valid word
// -----------------------------------------------------------------------------
module bram_rd_pipe
    import bram_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic have_data,
    input  logic out_ready,
    output logic issue,
    output logic adv2,
    output logic out_valid
);

    logic [RD_LAT-1:0] valid;

    // Stage 2 loads when stage 1 has a word and stage 2 is empty or being
    // drained; stage 1 loads when there is a word to fetch and its current
    // content (if any) moves on this cycle. A clear suppresses both loads.
    assign adv2      = valid[0] & (~valid[1] | out_ready) & ~clear;
    assign issue     = have_data & (~valid[0] | adv2) & ~clear;
    assign out_valid = valid[1];

    // Valid bits follow the register loads; a word stays put while its
    // successor stage is stalled, so nothing is dropped or duplicated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else begin
            valid[0] <= issue | (valid[0] & ~adv2);
            valid[1] <= adv2 | (valid[1] & ~out_ready);
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fifo_ctrl
// FIFO controller that owns both ports of an external dual-port RAM. Port A
// writes the incoming stream; port B plus its two read registers form the
// output pipeline (see bram_rd_pipe).
// Ports:
//   clk_i, rst_ni                  - clock, asynchronous active-low reset
//   s_valid_i/s_ready_o/s_data_i   - input stream (ready = not full)
//   m_valid_o/m_ready_i/m_data_o   - output stream (data straight from RAM)
//   level_o                        - words held, including in-flight ones
//   ram_ena_o/ram_wea_o/ram_addra_o/ram_dina_o    - RAM write port A
//   ram_enb_o/ram_addrb_o/ram_regceb_o/ram_rstnb_o - RAM read port B
//   ram_doutb_i                    - RAM output register
// Optional: define BRAM_FIFO_FLUSH_EN to add flush_i, a synchronous discard
// of all content that also resets the RAM output register.
// -----------------------------------------------------------------------------
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
`ifdef BRAM_FIFO_FLUSH_EN
    input  logic                    flush_i,
`endif
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [DATA_WIDTH-1:0]   m_data_o,
    output logic [ADDR_LINES:0]     level_o,
    output logic                    ram_ena_o,
    output logic                    ram_wea_o,
    output logic [ADDR_LINES-1:0]   ram_addra_o,
    output logic [DATA_WIDTH-1:0]   ram_dina_o,
    output logic                    ram_enb_o,
    output logic [ADDR_LINES-1:0]   ram_addrb_o,
    output logic                    ram_regceb_o,
    output logic                    ram_rstnb_o,
    input  logic [DATA_WIDTH-1:0]   ram_doutb_i
);

    localparam int PTR_W = ptr_bits(ADDR_LINES);
    localparam int LVL_W = level_bits(ADDR_LINES);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [LVL_W-1:0] level_t;

    localparam level_t DEPTH_LVL = level_t'(depth_of(ADDR_LINES));

    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    level_t avail;
    level_t level;
    logic   flush;
    logic   push;
    logic   pop;
    logic   issue;
    logic   adv2;
    logic   out_valid;

`ifdef BRAM_FIFO_FLUSH_EN
    assign flush       = flush_i;
    assign ram_rstnb_o = ~flush_i;
`else
    assign flush       = 1'b0;
    assign ram_rstnb_o = 1'b1;
`endif

    // Full is judged on the registered level only, so a pop in the same
    // cycle never frees a slot for a push until the next cycle.
    assign s_ready_o = (level < DEPTH_LVL) & ~flush;
    assign push      = s_valid_i & s_ready_o;
    assign pop       = out_valid & m_ready_i & ~flush;

    assign ram_ena_o    = push;
    assign ram_wea_o    = push;
    assign ram_addra_o  = wr_ptr;
    assign ram_dina_o   = s_data_i;
    assign ram_enb_o    = issue;
    assign ram_addrb_o  = rd_ptr;
    assign ram_regceb_o = adv2;

    assign m_valid_o = out_valid;
    assign m_data_o  = ram_doutb_i;
    assign level_o   = level;

    bram_rd_pipe u_rd_pipe (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (flush),
        .have_data (avail != '0),
        .out_ready (m_ready_i),
        .issue     (issue),
        .adv2      (adv2),
        .out_valid (out_valid)
    );

    // Pointers wrap naturally at DEPTH. avail counts words written but not
    // yet fetched; because it only rises after the write edge, a word is
    // never read in the same cycle it is written. level counts everything
    // from push to pop, including words sitting in the read registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            avail  <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            avail  <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            unique case ({push, issue})
                2'b10:   avail <= avail + level_t'(1);
                2'b01:   avail <= avail - level_t'(1);
                default: avail <= avail;
            endcase
            unique case ({push, pop})
                2'b10:   level <= level + level_t'(1);
                2'b01:   level <= level - level_t'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_fifo_ctrl
// Directed bench for bram_fifo_ctrl (DEPTH 16) with a behavioural dual-port
// RAM holding the two read registers. A small queue tracks accepted words so
// output order and level can be checked every cycle.
// -----------------------------------------------------------------------------
module tb_bram_fifo_ctrl;

    localparam int DW = 32;
    localparam int AL = 4;

    logic            clk;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic [AL:0]     level;
    logic            ram_ena;
    logic            ram_wea;
    logic [AL-1:0]   ram_addra;
    logic [DW-1:0]   ram_dina;
    logic            ram_enb;
    logic [AL-1:0]   ram_addrb;
    logic            ram_regceb;
    logic            ram_rstnb;
    logic [DW-1:0]   ram_doutb;
`ifdef BRAM_FIFO_FLUSH_EN
    logic            flush;
`endif

    int              checks;
    int              failures;
    int              popped;
    logic [DW-1:0]   sb[$];

    logic [DW-1:0]   mem [1<<AL];
    logic [DW-1:0]   ram_data_b;

    bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_LINES(AL)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
`ifdef BRAM_FIFO_FLUSH_EN
        .flush_i      (flush),
`endif
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .level_o      (level),
        .ram_ena_o    (ram_ena),
        .ram_wea_o    (ram_wea),
        .ram_addra_o  (ram_addra),
        .ram_dina_o   (ram_dina),
        .ram_enb_o    (ram_enb),
        .ram_addrb_o  (ram_addrb),
        .ram_regceb_o (ram_regceb),
        .ram_rstnb_o  (ram_rstnb),
        .ram_doutb_i  (ram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write port A, read register then output register on B.
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_enb) ram_data_b <= mem[ram_addrb];
        if (!ram_rstnb) ram_doutb <= '0;
        else if (ram_regceb) ram_doutb <= ram_data_b;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge, track push/pop in the queue, advance to
    // the next negedge and compare level with the queue occupancy.
    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic ready);
        s_valid = valid;
        s_data  = data;
        m_ready = ready;
        #1;
        if (valid && s_ready) sb.push_back(data);
        if (m_valid && ready) begin
            if (sb.size() == 0) begin
                checkOutput("pop_without_push", 64'd1, 64'd0);
            end else begin
                checkOutput("m_data_order", m_data, sb[0]);
                void'(sb.pop_front());
                popped++;
            end
        end
        @(negedge clk);
        checkOutput("level_track", level, sb.size());
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 80) begin
            applyStimulus(1'b0, '0, 1'b1);
            budget++;
        end
        checkOutput("drain_done", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int sent;
        int start_pop;
        int cyc;
        logic [15:0] pattern;

        checks   = 0;
        failures = 0;
        popped   = 0;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
`ifdef BRAM_FIFO_FLUSH_EN
        flush    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_rstnb", ram_rstnb, 1);
        checkOutput("rst_ena", ram_ena, 0);
        checkOutput("rst_enb", ram_enb, 0);
        checkOutput("rst_regceb", ram_regceb, 0);

        // Single word, latency 3
        s_valid = 1'b1; s_data = 32'hA5A5_A5A5; m_ready = 1'b1;
        #1;
        checkOutput("single_ena", ram_ena, 1);
        checkOutput("single_addra", ram_addra, 0);
        applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b1);
        checkOutput("single_lvl1", level, 1);
        checkOutput("single_c1_valid", m_valid, 0);
        checkOutput("single_c1_enb", ram_enb, 1);
        checkOutput("single_c1_addrb", ram_addrb, 0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_c2_valid", m_valid, 0);
        checkOutput("single_c2_regceb", ram_regceb, 1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_c3_valid", m_valid, 1);
        checkOutput("single_c3_data", m_data, 32'hA5A5_A5A5);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_c4_valid", m_valid, 0);
        checkOutput("single_lvl0", level, 0);

        // Fill to 16 without draining
        for (int i = 0; i < 16; i++) begin
            checkOutput("fill_s_ready", s_ready, 1);
            applyStimulus(1'b1, 32'h100 + i, 1'b0);
        end
        checkOutput("full_level", level, 16);
        checkOutput("full_s_ready", s_ready, 0);
        s_valid = 1'b1; s_data = 32'hDEAD; m_ready = 1'b0;
        #1;
        checkOutput("full_17th_ena", ram_ena, 0);
        applyStimulus(1'b1, 32'hDEAD, 1'b0);
        checkOutput("full_17th_level", level, 16);
        checkOutput("full_m_valid", m_valid, 1);
        checkOutput("full_m_data", m_data, 32'h100);

        // At full with a pop, push is blocked, then accepted next cycle
        s_valid = 1'b1; s_data = 32'h110; m_ready = 1'b1;
        #1;
        checkOutput("full_pop_push_blocked", ram_ena, 0);
        applyStimulus(1'b1, 32'h110, 1'b1);
        checkOutput("after_pop_level", level, 15);
        checkOutput("after_pop_s_ready", s_ready, 1);
        applyStimulus(1'b1, 32'h110, 1'b0);
        checkOutput("refill_level", level, 16);
        drain();
        checkOutput("drain_level", level, 0);
        checkOutput("drain_m_valid", m_valid, 0);

        // Simultaneous push and pop at level 8
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h200 + i, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("lvl8_level", level, 8);
        checkOutput("lvl8_m_valid", m_valid, 1);
        checkOutput("lvl8_m_data", m_data, 32'h200);
        applyStimulus(1'b1, 32'h208, 1'b1);
        checkOutput("lvl8_pushpop_level", level, 8);
        drain();

        // Backpressure: 0..31 with a fixed irregular ready pattern
        pattern   = 16'b1011_0010_1110_0101;
        sent      = 0;
        start_pop = popped;
        cyc       = 0;
        while ((popped - start_pop) < 32 && cyc < 400) begin
            if (sent < 32 && s_ready) begin
                applyStimulus(1'b1, DW'(sent), pattern[cyc % 16]);
                sent++;
            end else begin
                applyStimulus(1'b0, '0, pattern[cyc % 16]);
            end
            cyc++;
        end
        checkOutput("bp_count", popped - start_pop, 32);
        checkOutput("bp_level", level, 0);

        // Wrap: 40 words at full rate, must finish within 43 cycles
        sent      = 0;
        start_pop = popped;
        cyc       = 0;
        while ((popped - start_pop) < 40 && cyc < 60) begin
            if (sent < 40) begin
                applyStimulus(1'b1, 32'h5000 + sent, 1'b1);
                sent++;
            end else begin
                applyStimulus(1'b0, '0, 1'b1);
            end
            cyc++;
        end
        checkOutput("wrap_count", popped - start_pop, 40);
        checkOutput("wrap_cycles", cyc, 43);
        checkOutput("wrap_level", level, 0);

        // Mid-stream reset with 5 words in flight
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h300 + i, 1'b0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        sb.delete();
        checkOutput("midrst_m_valid", m_valid, 0);
        checkOutput("midrst_level", level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postrst_m_valid", m_valid, 0);
        checkOutput("postrst_level", level, 0);
        applyStimulus(1'b1, 32'h1234_5678, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("postrst_c2_valid", m_valid, 0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("postrst_c3_valid", m_valid, 1);
        checkOutput("postrst_c3_data", m_data, 32'h1234_5678);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("postrst_empty", m_valid, 0);

`ifdef BRAM_FIFO_FLUSH_EN
        // Flush with 5 words in flight, concurrent push ignored
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h400 + i, 1'b0);
        sb.delete();
        flush = 1'b1;
        s_valid = 1'b1; s_data = 32'h4FF; m_ready = 1'b1;
        #1;
        checkOutput("flush_s_ready", s_ready, 0);
        checkOutput("flush_rstnb", ram_rstnb, 0);
        checkOutput("flush_ena", ram_ena, 0);
        checkOutput("flush_enb", ram_enb, 0);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("postflush_m_valid", m_valid, 0);
        checkOutput("postflush_level", level, 0);
        checkOutput("postflush_doutb", m_data, 0);
        applyStimulus(1'b1, 32'hCAFE_F00D, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("postflush_c3_valid", m_valid, 1);
        checkOutput("postflush_c3_data", m_data, 32'hCAFE_F00D);
        applyStimulus(1'b0, '0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
